// File: rtl/shift_taps_pkg.sv
// Shared helpers for the shift_taps slice: counter sizing for the fill counter.
package shift_taps_pkg;

  // Ceiling log2, used at elaboration to size counters.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_taps_if.sv
// Sample stream and tap bus of shift_taps; master drives samples, slave is the delay line.
interface shift_taps_if #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 4
);
  logic                     ivalid;
  logic [WIDTH-1:0]         shiftin;
  logic                     ovalid;
  logic [WIDTH-1:0]         shiftout;
  logic [WIDTH*SHIFT-1:0]   taps;

  modport master (output ivalid, shiftin, input ovalid, shiftout, taps);
  modport slave  (input ivalid, shiftin, output ovalid, shiftout, taps);
endinterface

// File: rtl/shift_taps_stage.sv
// One delay-line stage: a WIDTH-bit register that loads only when enabled.
module shift_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage register: cleared asynchronously, holds while disabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_taps.sv
// Valid-gated delay line of SHIFT stages with a full-pipeline qualifier and a flat tap bus.
module shift_taps
  import shift_taps_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 4
) (
  input  logic          clock,
  input  logic          reset,
  shift_taps_if.slave   bus
);

  localparam int CNT_W = clog2(SHIFT + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(SHIFT);

  if (SHIFT < 1) begin : g_bad_shift
    $error("shift_taps: SHIFT must be at least 1");
  end

  logic [WIDTH-1:0] stage_s [SHIFT];
  logic [CNT_W-1:0] fill_r;
  logic [CNT_W-1:0] fill_nxt_s;
  logic             ovalid_r;
  logic             ovalid_nxt_s;

  for (genvar k = 0; k < SHIFT; k++) begin : g_stage
    logic [WIDTH-1:0] d_s;
    if (k == 0) begin : g_head
      assign d_s = bus.shiftin;
    end else begin : g_body
      assign d_s = stage_s[k-1];
    end
    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clock (clock),
      .reset (reset),
      .en    (bus.ivalid),
      .d     (d_s),
      .q     (stage_s[k])
    );
    assign bus.taps[k*WIDTH +: WIDTH] = stage_s[k];
  end

  // Fill count saturates at SHIFT so ovalid never drops on a long stream.
  always_comb begin
    fill_nxt_s   = fill_r;
    ovalid_nxt_s = 1'b0;
    if (bus.ivalid) begin
      if (fill_r != FULL) begin
        fill_nxt_s = fill_r + CNT_W'(1);
      end else begin
        fill_nxt_s = fill_r;
      end
      ovalid_nxt_s = (fill_nxt_s == FULL);
    end else begin
      fill_nxt_s   = fill_r;
      ovalid_nxt_s = 1'b0;
    end
  end

  // Fill counter and output qualifier registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fill_r   <= '0;
      ovalid_r <= 1'b0;
    end else begin
      fill_r   <= fill_nxt_s;
      ovalid_r <= ovalid_nxt_s;
    end
  end

  assign bus.shiftout = stage_s[SHIFT-1];
  assign bus.ovalid   = ovalid_r;

endmodule

// File: tb/tb_shift_taps.sv
// Directed bench for shift_taps: a SHIFT=4 instance and a SHIFT=1 instance fed the same stream.
module tb_shift_taps;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  shift_taps_if #(.WIDTH(32), .SHIFT(4)) bus4 ();
  shift_taps_if #(.WIDTH(32), .SHIFT(1)) bus1 ();

  shift_taps #(.WIDTH(32), .SHIFT(4)) u_dut4 (.clock(sys_clk), .reset(rst_n), .bus(bus4));
  shift_taps #(.WIDTH(32), .SHIFT(1)) u_dut1 (.clock(sys_clk), .reset(rst_n), .bus(bus1));

  always #5 sys_clk = ~sys_clk;

  task automatic drive(input logic v, input logic [31:0] d);
    bus4.ivalid  = v;
    bus4.shiftin = d;
    bus1.ivalid  = v;
    bus1.shiftin = d;
  endtask

  // Apply one input, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic v, input logic [31:0] d);
    drive(v, d);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0);
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hDEAD_BEEF);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge sys_clk);
      #1;
      tests_run++;
      if (bus4.shiftout !== 32'd0) begin
        tests_failed++;
        $display("FAIL reset_shiftout cyc=%0d got=%h exp=0", i, bus4.shiftout);
      end
      tests_run++;
      if (bus4.taps !== 128'd0) begin
        tests_failed++;
        $display("FAIL reset_taps cyc=%0d got=%h exp=0", i, bus4.taps);
      end
      tests_run++;
      if (bus4.ovalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ovalid cyc=%0d got=%b exp=0", i, bus4.ovalid);
      end
      tests_run++;
      if (bus1.shiftout !== 32'd0 || bus1.ovalid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_s1 cyc=%0d got=%h/%b exp=0/0", i, bus1.shiftout, bus1.ovalid);
      end
    end
    rst_n = 1'b1;
    step(1'b1, 32'd7);
    step(1'b1, 32'd8);
    tests_run++;
    if (bus4.taps[63:0] !== {32'd7, 32'd8}) begin
      tests_failed++;
      $display("FAIL reset_prefill got=%h exp=%h", bus4.taps[63:0], {32'd7, 32'd8});
    end
    // Assert reset between edges: outputs must clear immediately.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus4.taps !== 128'd0 || bus4.ovalid !== 1'b0 || bus1.ovalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async got=%h/%b exp=0/0", bus4.taps, bus4.ovalid);
    end
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_continuous();
    logic [127:0] exp_taps;
    logic [31:0]  exp_out;
    do_reset();
    for (int n = 1; n <= 8; n++) begin
      step(1'b1, 32'(n));
      exp_taps = '0;
      for (int k = 0; k < 4; k++) begin
        exp_taps[k*32 +: 32] = (n - k >= 1) ? 32'(n - k) : 32'd0;
      end
      exp_out = (n >= 4) ? 32'(n - 3) : 32'd0;
      tests_run++;
      if (bus4.ovalid !== (n >= 4)) begin
        tests_failed++;
        $display("FAIL cont_ovalid n=%0d got=%b exp=%b", n, bus4.ovalid, (n >= 4));
      end
      tests_run++;
      if (bus4.taps !== exp_taps) begin
        tests_failed++;
        $display("FAIL cont_taps n=%0d got=%h exp=%h", n, bus4.taps, exp_taps);
      end
      tests_run++;
      if (bus4.shiftout !== exp_out) begin
        tests_failed++;
        $display("FAIL cont_shiftout n=%0d got=%0d exp=%0d", n, bus4.shiftout, exp_out);
      end
    end
  endtask

  task automatic test_gapped();
    logic         v_tab [9];
    logic [31:0]  d_tab [9];
    logic [127:0] t_tab [9];
    logic         o_tab [9];
    v_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    d_tab = '{32'd10, 32'd11, 32'hFFFF_FFFF, 32'd12, 32'h5555_5555, 32'hAAAA_AAAA,
              32'd13, 32'd14, 32'h1234_5678};
    t_tab = '{{32'd0,  32'd0,  32'd0,  32'd10},
              {32'd0,  32'd0,  32'd10, 32'd11},
              {32'd0,  32'd0,  32'd10, 32'd11},
              {32'd0,  32'd10, 32'd11, 32'd12},
              {32'd0,  32'd10, 32'd11, 32'd12},
              {32'd0,  32'd10, 32'd11, 32'd12},
              {32'd10, 32'd11, 32'd12, 32'd13},
              {32'd11, 32'd12, 32'd13, 32'd14},
              {32'd11, 32'd12, 32'd13, 32'd14}};
    o_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(v_tab[i], d_tab[i]);
      tests_run++;
      if (bus4.taps !== t_tab[i]) begin
        tests_failed++;
        $display("FAIL gap_taps i=%0d got=%h exp=%h", i, bus4.taps, t_tab[i]);
      end
      tests_run++;
      if (bus4.shiftout !== t_tab[i][127:96]) begin
        tests_failed++;
        $display("FAIL gap_shiftout i=%0d got=%0d exp=%0d", i, bus4.shiftout, t_tab[i][127:96]);
      end
      tests_run++;
      if (bus4.ovalid !== o_tab[i]) begin
        tests_failed++;
        $display("FAIL gap_ovalid i=%0d got=%b exp=%b", i, bus4.ovalid, o_tab[i]);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, 32'(n));
    end
    tests_run++;
    if (bus4.shiftout !== 32'd17 || bus4.ovalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_prerun got=%0d/%b exp=17/1", bus4.shiftout, bus4.ovalid);
    end
    drive(1'b1, 32'd21);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus4.taps !== 128'd0 || bus4.ovalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_async got=%h/%b exp=0/0", bus4.taps, bus4.ovalid);
    end
    @(posedge sys_clk);
    #1;
    tests_run++;
    if (bus4.taps !== 128'd0 || bus4.ovalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_held got=%h/%b exp=0/0", bus4.taps, bus4.ovalid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(100 + i));
      tests_run++;
      if (bus4.ovalid !== (i == 3)) begin
        tests_failed++;
        $display("FAIL mid_ovalid i=%0d got=%b exp=%b", i, bus4.ovalid, (i == 3));
      end
    end
    tests_run++;
    if (bus4.shiftout !== 32'd100) begin
      tests_failed++;
      $display("FAIL mid_shiftout got=%0d exp=100", bus4.shiftout);
    end
    tests_run++;
    if (bus4.taps !== {32'd100, 32'd101, 32'd102, 32'd103}) begin
      tests_failed++;
      $display("FAIL mid_taps got=%h exp=%h", bus4.taps, {32'd100, 32'd101, 32'd102, 32'd103});
    end
  endtask

  task automatic test_shift1();
    do_reset();
    for (int v = 5; v <= 7; v++) begin
      step(1'b1, 32'(v));
      tests_run++;
      if (bus1.shiftout !== 32'(v) || bus1.taps !== 32'(v)) begin
        tests_failed++;
        $display("FAIL s1_data v=%0d got=%0d/%0d exp=%0d", v, bus1.shiftout, bus1.taps, v);
      end
      tests_run++;
      if (bus1.ovalid !== 1'b1) begin
        tests_failed++;
        $display("FAIL s1_ovalid v=%0d got=%b exp=1", v, bus1.ovalid);
      end
    end
    step(1'b0, 32'd99);
    tests_run++;
    if (bus1.shiftout !== 32'd7 || bus1.ovalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL s1_idle got=%0d/%b exp=7/0", bus1.shiftout, bus1.ovalid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 1003; i++) begin
      step(1'b1, 32'(5000 + i));
      if (i >= 3) begin
        tests_run++;
        if (bus4.ovalid !== 1'b1 || bus4.shiftout !== 32'(5000 + i - 3)) begin
          tests_failed++;
          $display("FAIL sat4 i=%0d got=%0d/%b exp=%0d/1", i, bus4.shiftout, bus4.ovalid, 5000 + i - 3);
        end
      end
      tests_run++;
      if (bus1.ovalid !== 1'b1 || bus1.shiftout !== 32'(5000 + i)) begin
        tests_failed++;
        $display("FAIL sat1 i=%0d got=%0d/%b exp=%0d/1", i, bus1.shiftout, bus1.ovalid, 5000 + i);
      end
    end
  endtask

  initial begin
    drive(1'b0, 32'd0);
    test_reset();
    test_continuous();
    test_gapped();
    test_midreset();
    test_shift1();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_taps.md
Name: shift_taps

Overview:
- Valid-gated shift register with taps. It delays a WIDTH-bit sample stream by SHIFT accepted samples.
- The register advances only on cycles where ivalid is high. Idle cycles do not age the data.
- It exposes the delayed word with a qualifying ovalid flag, plus every intermediate stage as a flat tap bus.
- Used in datapaths for sample alignment, where a plain clocked delay would miscount across input gaps.

Parameters:
- WIDTH, 32, bit width of each sample.
- SHIFT, 4, number of stages, i.e. delay in accepted samples. Legal range is 1 or more; elaboration fails for SHIFT < 1.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; state releases on the next clock edge after reset returns to 1.
- ivalid  input  1  shiftin is valid this cycle; an accepting edge is a rising edge with ivalid=1.
- shiftin  input  WIDTH  input sample.
- ovalid  output  1  shiftout holds a freshly shifted, fully delayed sample.
- shiftout  output  WIDTH  final stage (stage SHIFT-1).
- taps  output  WIDTH*SHIFT  all stages concatenated; slice [k*WIDTH +: WIDTH] is stage k, stage 0 is the newest.

Behaviour:
- Storage is SHIFT registers, stage[0]..stage[SHIFT-1], all registered. shiftout = stage[SHIFT-1], and taps is driven directly from the stages.
- Reset (reset=0, asynchronous) clears:
  - all stages to 0, so shiftout=0 and taps=0;
  - ovalid to 0;
  - the fill counter to 0.
- On an accepting edge:
  - stage[0] <= shiftin;
  - stage[k] <= stage[k-1] for k = 1..SHIFT-1;
  - the fill counter increments, saturating at SHIFT.
- On a non-accepting edge (ivalid=0): all stages and the fill counter hold; ovalid <= 0.
- Latency: a sample accepted on accepting edge n appears on shiftout after accepting edge n+SHIFT-1.
  - With continuous ivalid, this is SHIFT-1 clock edges after capture.
  - For SHIFT=1, shiftout is the sample captured on the most recent accepting edge.
- ovalid is registered. After an accepting edge, ovalid = 1 iff the fill count after that edge has reached SHIFT (at least SHIFT samples accepted since reset); otherwise 0.
  - ovalid therefore pulses 1 only on cycles following accepting edges once the pipeline is full.
  - It stays 0 during fill and after any idle edge.
- Fill counter:
  - width is clog2(SHIFT+1);
  - it never wraps;
  - only reset clears it, never an ivalid gap.
- Gaps in ivalid: contents are frozen, and relative ordering and delay (in accepted samples) are preserved exactly.
- Reset mid-stream: all contents are discarded. The next SHIFT accepted samples refill the pipeline and ovalid stays 0 until the fill count reaches SHIFT again.
- Reset asserted at the same time as ivalid: reset wins and nothing is captured.
- No backpressure: the block always accepts a valid input.
- Purely a data-movement block: no arithmetic on data; data width is preserved bit-exactly.

Decomposition:
- No shared package needed. The only shared item is the optional clog2 helper for the counter width, taken from the existing common utility package if one is present.
- One natural sub-module: shift_stage, a WIDTH-bit register with async active-low reset and enable (enable = ivalid).
  - Instantiate it SHIFT times in a generate loop.
  - The fill counter and ovalid register live in the top-level module.

Test Plan:
- Reset check: hold reset=0 with shiftin=0xDEADBEEF and ivalid=1 -> shiftout=0, taps=0, ovalid=0 throughout; assert reset mid-run -> outputs clear without waiting for a clock edge.
- Continuous stream (WIDTH=32, SHIFT=4): after reset release, present 1,2,3,... with ivalid=1 every cycle ->
  - ovalid=0 after accepting edges 1-3 and 1 from edge 4 onward;
  - after edge n (n≥4), shiftout = n-3 and taps = {n-3, n-2, n-1, n} (stage3..stage0).
- Gapped stream: ivalid pattern 1,1,0,1,0,0,1,1 carrying values 10,11,x,12,x,x,13,14 -> stages freeze on the 0 cycles and ovalid=0 after each idle edge; shiftout=10 and ovalid=1 after the edge accepting 13; shiftout=11 after the edge accepting 14.
- Mid-stream reset: run the continuous stream to value 20, pulse reset low for one cycle, resume at 100 ->
  - all outputs clear during reset;
  - ovalid stays 0 until the 4th accepting edge after release;
  - then shiftout = 100.
- SHIFT=1 corner: stream 5,6,7 -> shiftout equals the last accepted value after each accepting edge; ovalid=1 from the first accepting edge.
- Saturation: 1000 continuous accepting edges -> ovalid remains 1 continuously (no counter wrap glitch) and shiftout always equals the input from 3 accepting edges earlier.
